debug_host: RTL and testbench

- Upstream debug sequencer for the 8-bit SAP-style CPU core.
- Consumes a byte-command stream from the serial front end (UART/SPI deserializer). Drives the core's debug handshake (DEBUG_REQUEST/DEBUG_ACK), DEBUG_DATA and the D_* control strobes.
- Executes single-cycle datapath micro-operations while the core is parked in debug.
- Returns one response byte per command on a byte-stream output.

---
 rtl/debug_host_pkg.sv | 59 +++++
 rtl/debug_host_strobe_gen.sv | 41 ++++
 rtl/debug_host.sv | 218 +++++++++++++++++++++
 tb/tb_debug_host.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_host_pkg.sv
// Shared definitions for the debug sequencer: opcodes, response codes,
// bus-source encodings, sequencer states and the packed control word.
package debug_host_pkg;

  localparam logic [7:0] CMD_ATTACH = 8'h01;
  localparam logic [7:0] CMD_DETACH = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_EXEC   = 8'h10;

  localparam logic [7:0] RSP_OK       = 8'hA5;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hE1;
  localparam logic [7:0] RSP_DETACHED = 8'hE2;
  localparam logic [7:0] RSP_BADCMD   = 8'hEF;

  localparam logic [2:0] SRC_DO = 3'd0;
  localparam logic [2:0] SRC_AO = 3'd1;
  localparam logic [2:0] SRC_BO = 3'd2;
  localparam logic [2:0] SRC_IO = 3'd3;
  localparam logic [2:0] SRC_CO = 3'd4;
  localparam logic [2:0] SRC_EO = 3'd5;
  localparam logic [2:0] SRC_RO = 3'd6;
  localparam logic [2:0] SRC_NO = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_OPERAND     = 3'd1,
    ST_ATTACH_WAIT = 3'd2,
    ST_DETACH_WAIT = 3'd3,
    ST_EXEC        = 3'd4,
    ST_RESP        = 3'd5
  } state_t;

  typedef struct packed {
    logic clr;
    logic hlt;
    logic ce;
    logic su;
    logic ri;
    logic ai_n;
    logic bi_n;
    logic oi_n;
    logic ii_n;
    logic j_n;
    logic fi_n;
    logic mi_n;
    logic do_n;
    logic ao_n;
    logic bo_n;
    logic io_n;
    logic co_n;
    logic eo_n;
    logic ro_n;
    logic no_n;
  } ctrl_t;

  // Nothing driven, nothing loaded: high strobes low, low strobes high.
  localparam ctrl_t CTRL_IDLE = ctrl_t'({5'b00000, 7'b1111111, 8'b11111111});

endpackage

// File: rtl/debug_host_strobe_gen.sv
// Combinational map from EXEC operands to the 20 core control levels.
// Inactive yields the idle control word; the parent registers the result.
module debug_strobe_gen
  import debug_host_pkg::*;
(
  input  logic [2:0] src,
  input  logic [7:0] load,
  input  logic [3:0] misc,
  input  logic       active,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    if (active) begin
      unique case (src)
        SRC_DO:  ctrl.do_n = 1'b0;
        SRC_AO:  ctrl.ao_n = 1'b0;
        SRC_BO:  ctrl.bo_n = 1'b0;
        SRC_IO:  ctrl.io_n = 1'b0;
        SRC_CO:  ctrl.co_n = 1'b0;
        SRC_EO:  ctrl.eo_n = 1'b0;
        SRC_RO:  ctrl.ro_n = 1'b0;
        default: ctrl.no_n = 1'b0;
      endcase
      ctrl.ai_n = ~load[0];
      ctrl.bi_n = ~load[1];
      ctrl.oi_n = ~load[2];
      ctrl.ii_n = ~load[3];
      ctrl.j_n  = ~load[4];
      ctrl.fi_n = ~load[5];
      ctrl.mi_n = ~load[6];
      ctrl.ri   = load[7];
      ctrl.ce   = misc[0];
      ctrl.su   = misc[1];
      ctrl.clr  = misc[2];
      ctrl.hlt  = misc[3];
    end
  end

endmodule

// File: rtl/debug_host.sv
// Byte-command debug sequencer: attaches to the core, runs one-cycle datapath
// micro-ops while parked, and answers every command with one response byte.
module debug_host
  import debug_host_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       DEBUG_REQUEST,
  input  logic       DEBUG_ACK,
  input  logic       HALTED,
  input  logic [7:0] BUS,
  output logic [7:0] DEBUG_DATA,
  output logic       D_CLR,
  output logic       D_HLT,
  output logic       D_CE,
  output logic       D_SU,
  output logic       D_RI,
  output logic       D_AIn,
  output logic       D_BIn,
  output logic       D_OIn,
  output logic       D_IIn,
  output logic       D_Jn,
  output logic       D_FIn,
  output logic       D_MIn,
  output logic       D_DOn,
  output logic       D_AOn,
  output logic       D_BOn,
  output logic       D_IOn,
  output logic       D_COn,
  output logic       D_EOn,
  output logic       D_ROn,
  output logic       D_NOn
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Handshakes: a byte/response moves on a posedge where VALID and READY are
  // both high; TX_DATA is held constant while TX_VALID is high.
  state_t     state_q, state_d;
  logic       req_q, req_d;
  logic [7:0] dbg_data_q, dbg_data_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       rx_ready_q, rx_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] op_data_q, op_data_d;
  logic [2:0] src_q, src_d;
  logic [7:0] load_q, load_d;

  logic  rx_fire, tx_fire, exec_go;
  ctrl_t exec_ctrl;

  assign rx_fire = RX_VALID & rx_ready_q;
  assign tx_fire = tx_valid_q & TX_READY;
  assign exec_go = (state_q == ST_OPERAND) && (idx_q == 2'd3) && rx_fire && DEBUG_ACK;

  // The final operand (MISC) is still on RX_DATA on the edge that enters EXEC.
  debug_strobe_gen u_strobe_gen (
    .src    (src_q),
    .load   (load_q),
    .misc   (RX_DATA[3:0]),
    .active (exec_go),
    .ctrl   (exec_ctrl)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    dbg_data_d = dbg_data_q;
    ctrl_d     = CTRL_IDLE;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    op_data_d  = op_data_q;
    src_d      = src_q;
    load_d     = load_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          state_d = ST_RESP;
          unique case (RX_DATA)
            CMD_ATTACH: begin
              req_d = 1'b1;
              cnt_d = '0;
              if (DEBUG_ACK) tx_data_d = RSP_OK;
              else           state_d   = ST_ATTACH_WAIT;
            end
            CMD_DETACH: begin
              req_d   = 1'b0;
              state_d = ST_DETACH_WAIT;
            end
            CMD_STATUS: tx_data_d = {6'b0, HALTED, DEBUG_ACK};
            CMD_EXEC: begin
              idx_d   = 2'd0;
              state_d = ST_OPERAND;
            end
            default: tx_data_d = RSP_BADCMD;
          endcase
        end
      end
      ST_OPERAND: begin
        if (rx_fire) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: op_data_d = RX_DATA;
            2'd1: src_d     = RX_DATA[2:0];
            2'd2: load_d    = RX_DATA;
            default: begin
              if (DEBUG_ACK) begin
                state_d    = ST_EXEC;
                ctrl_d     = exec_ctrl;
                dbg_data_d = op_data_q;
              end else begin
                state_d   = ST_RESP;
                tx_data_d = RSP_DETACHED;
              end
            end
          endcase
        end
      end
      ST_ATTACH_WAIT: begin
        if (DEBUG_ACK) begin
          state_d   = ST_RESP;
          tx_data_d = RSP_OK;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_RESP;
          req_d     = 1'b0;
          tx_data_d = RSP_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DETACH_WAIT: begin
        if (!DEBUG_ACK) begin
          state_d   = ST_RESP;
          tx_data_d = RSP_OK;
        end
      end
      ST_EXEC: begin
        state_d   = ST_RESP;
        tx_data_d = BUS;
      end
      ST_RESP: begin
        if (tx_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_valid_d = (state_d == ST_RESP);
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_OPERAND);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      dbg_data_q <= 8'h00;
      ctrl_q     <= CTRL_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      op_data_q  <= 8'h00;
      src_q      <= 3'd0;
      load_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      dbg_data_q <= dbg_data_d;
      ctrl_q     <= ctrl_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_data_q  <= op_data_d;
      src_q      <= src_d;
      load_q     <= load_d;
    end
  end

  assign RX_READY      = rx_ready_q;
  assign TX_DATA       = tx_data_q;
  assign TX_VALID      = tx_valid_q;
  assign DEBUG_REQUEST = req_q;
  assign DEBUG_DATA    = dbg_data_q;
  assign D_CLR = ctrl_q.clr;
  assign D_HLT = ctrl_q.hlt;
  assign D_CE  = ctrl_q.ce;
  assign D_SU  = ctrl_q.su;
  assign D_RI  = ctrl_q.ri;
  assign D_AIn = ctrl_q.ai_n;
  assign D_BIn = ctrl_q.bi_n;
  assign D_OIn = ctrl_q.oi_n;
  assign D_IIn = ctrl_q.ii_n;
  assign D_Jn  = ctrl_q.j_n;
  assign D_FIn = ctrl_q.fi_n;
  assign D_MIn = ctrl_q.mi_n;
  assign D_DOn = ctrl_q.do_n;
  assign D_AOn = ctrl_q.ao_n;
  assign D_BOn = ctrl_q.bo_n;
  assign D_IOn = ctrl_q.io_n;
  assign D_COn = ctrl_q.co_n;
  assign D_EOn = ctrl_q.eo_n;
  assign D_ROn = ctrl_q.ro_n;
  assign D_NOn = ctrl_q.no_n;

endmodule

// File: tb/tb_debug_host.sv
// Self-checking bench for debug_host: scenario tasks drive commands, a
// response queue holds expected bytes, each task compares inline.
module tb_debug_host;

  localparam int TMO = 8;
  localparam logic [19:0] IDLE_W = 20'b00000_1111111_11111111;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic       RX_READY;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY = 1'b0;
  logic       DEBUG_REQUEST;
  logic       DEBUG_ACK = 1'b0;
  logic       HALTED = 1'b0;
  logic [7:0] BUS;
  logic [7:0] DEBUG_DATA;
  logic D_CLR, D_HLT, D_CE, D_SU, D_RI;
  logic D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn;
  logic D_DOn, D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn;

  logic [7:0] bus_drv = 8'h00;
  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Bus model: the debug port wins when D_DOn is low, otherwise a core source.
  assign BUS = D_DOn ? bus_drv : DEBUG_DATA;

  always #5 CLK = ~CLK;

  debug_host #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .DEBUG_REQUEST(DEBUG_REQUEST), .DEBUG_ACK(DEBUG_ACK), .HALTED(HALTED),
    .BUS(BUS), .DEBUG_DATA(DEBUG_DATA),
    .D_CLR(D_CLR), .D_HLT(D_HLT), .D_CE(D_CE), .D_SU(D_SU), .D_RI(D_RI),
    .D_AIn(D_AIn), .D_BIn(D_BIn), .D_OIn(D_OIn), .D_IIn(D_IIn),
    .D_Jn(D_Jn), .D_FIn(D_FIn), .D_MIn(D_MIn),
    .D_DOn(D_DOn), .D_AOn(D_AOn), .D_BOn(D_BOn), .D_IOn(D_IOn),
    .D_COn(D_COn), .D_EOn(D_EOn), .D_ROn(D_ROn), .D_NOn(D_NOn)
  );

  function automatic logic [19:0] obs_ctrl();
    return {D_CLR, D_HLT, D_CE, D_SU, D_RI,
            D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn,
            D_DOn, D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!RX_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  // Waits (bounded) for a response, consumes it, reports cycles waited.
  task automatic wait_tx(output logic [7:0] d, output int n, output bit ok);
    n = 0;
    while (!TX_VALID && n < 400) begin
      @(negedge CLK);
      n++;
    end
    ok = TX_VALID;
    d  = TX_DATA;
    if (ok) begin
      TX_READY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      TX_READY = 1'b0;
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    #1;
    total++; if (obs_ctrl() !== IDLE_W) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", obs_ctrl(), IDLE_W); end
    total++; if (DEBUG_REQUEST !== 1'b0 || TX_VALID !== 1'b0 || RX_READY !== 1'b1) begin
      bad++; $display("FAIL reset_hs got req=%b txv=%b rxr=%b exp 0 0 1", DEBUG_REQUEST, TX_VALID, RX_READY); end
    total++; if (TX_DATA !== 8'h00 || DEBUG_DATA !== 8'h00) begin
      bad++; $display("FAIL reset_data got tx=%h dd=%h exp 00 00", TX_DATA, DEBUG_DATA); end
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_attach_ack();
    logic [7:0] d, e; int n; bit ok;
    DEBUG_ACK = 1'b0;
    send_byte(8'h01);
    exp_q.push_back(8'hA5);
    repeat (3) @(negedge CLK);
    total++; if (DEBUG_REQUEST !== 1'b1 || TX_VALID !== 1'b0) begin
      bad++; $display("FAIL attach_wait got req=%b txv=%b exp 1 0", DEBUG_REQUEST, TX_VALID); end
    DEBUG_ACK = 1'b1;
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL attach_ack got=%h ok=%0d exp=%h", d, ok, e); end
    total++; if (DEBUG_REQUEST !== 1'b1) begin bad++; $display("FAIL attach_req_hold got=%b exp=1", DEBUG_REQUEST); end
  endtask

  task automatic test_detach_and_timeout();
    logic [7:0] d, e; int n; bit ok;
    DEBUG_ACK = 1'b0;
    send_byte(8'h02);
    exp_q.push_back(8'hA5);
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e || DEBUG_REQUEST !== 1'b0) begin
      bad++; $display("FAIL detach got=%h req=%b exp=%h req=0", d, DEBUG_REQUEST, e); end
    send_byte(8'h01);
    exp_q.push_back(8'hE1);
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL attach_timeout got=%h exp=%h", d, e); end
    total++; if (n !== TMO) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TMO); end
    total++; if (DEBUG_REQUEST !== 1'b0) begin bad++; $display("FAIL timeout_req got=%b exp=0", DEBUG_REQUEST); end
  endtask

  task automatic test_attach_immediate();
    logic [7:0] d, e; int n; bit ok;
    DEBUG_ACK = 1'b1;
    send_byte(8'h01);
    exp_q.push_back(8'hA5);
    total++; if (TX_VALID !== 1'b1) begin bad++; $display("FAIL attach_immediate_lat got txv=%b exp=1", TX_VALID); end
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL attach_immediate got=%h exp=%h", d, e); end
  endtask

  task automatic test_exec(input logic [7:0] dat, input logic [7:0] src, input logic [7:0] ld,
                           input logic [7:0] misc, input logic [19:0] exp_w,
                           input logic [7:0] bus_v, input logic [7:0] rsp);
    logic [7:0] d, e; int n; bit ok;
    bus_drv = bus_v;
    send_byte(8'h10);
    send_byte(dat);
    send_byte(src);
    send_byte(ld);
    send_byte(misc);
    exp_q.push_back(rsp);
    total++; if (obs_ctrl() !== exp_w || DEBUG_DATA !== dat) begin
      bad++; $display("FAIL exec_strobes got=%b dd=%h exp=%b dd=%h", obs_ctrl(), DEBUG_DATA, exp_w, dat); end
    @(negedge CLK);
    total++; if (obs_ctrl() !== IDLE_W || TX_VALID !== 1'b1) begin
      bad++; $display("FAIL exec_one_cycle got=%b txv=%b exp=%b txv=1", obs_ctrl(), TX_VALID, IDLE_W); end
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL exec_resp got=%h exp=%h", d, e); end
    total++; if (DEBUG_DATA !== dat) begin bad++; $display("FAIL exec_dd_hold got=%h exp=%h", DEBUG_DATA, dat); end
  endtask

  task automatic test_exec_detached();
    logic [7:0] d, e; int n; bit ok;
    DEBUG_ACK = 1'b0;
    send_byte(8'h10);
    send_byte(8'h99);
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h0F);
    exp_q.push_back(8'hE2);
    total++; if (obs_ctrl() !== IDLE_W || DEBUG_DATA !== 8'h00) begin
      bad++; $display("FAIL exec_det_quiet got=%b dd=%h exp=%b dd=00", obs_ctrl(), DEBUG_DATA, IDLE_W); end
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e || DEBUG_REQUEST !== 1'b1) begin
      bad++; $display("FAIL exec_detached got=%h req=%b exp=%h req=1", d, DEBUG_REQUEST, e); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] d, e; int n; bit ok;
    send_byte(8'h7F);
    exp_q.push_back(8'hEF);
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL bad_opcode got=%h exp=%h", d, e); end
  endtask

  task automatic test_status_backpressure();
    logic [7:0] d, e; int n; bit ok;
    DEBUG_ACK = 1'b1;
    HALTED    = 1'b1;
    send_byte(8'h03);
    exp_q.push_back(8'h03);
    RX_DATA  = 8'h7F;
    RX_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      HALTED = 1'(($urandom_range(0, 1)));
      total++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h03 || RX_READY !== 1'b0) begin
        bad++; $display("FAIL hold_%0d got txv=%b tx=%h rxr=%b exp 1 03 0", i, TX_VALID, TX_DATA, RX_READY); end
      @(negedge CLK);
    end
    RX_VALID = 1'b0;
    wait_tx(d, n, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL status got=%h exp=%h", d, e); end
    @(negedge CLK);
    total++; if (TX_VALID !== 1'b0 || RX_READY !== 1'b1) begin
      bad++; $display("FAIL rx_ignored got txv=%b rxr=%b exp 0 1", TX_VALID, RX_READY); end
  endtask

  task automatic test_reset_mid_exec();
    DEBUG_ACK = 1'b1;
    send_byte(8'h10);
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'hFF);
    send_byte(8'h0F);
    total++; if (obs_ctrl() !== 20'b11111_0000000_11011111) begin
      bad++; $display("FAIL pre_reset_exec got=%b exp=%b", obs_ctrl(), 20'b11111_0000000_11011111); end
    #1 RESETn = 1'b0;
    #1;
    total++; if (obs_ctrl() !== IDLE_W || DEBUG_REQUEST !== 1'b0 || TX_VALID !== 1'b0) begin
      bad++; $display("FAIL reset_mid_exec got=%b req=%b txv=%b exp=%b 0 0", obs_ctrl(), DEBUG_REQUEST, TX_VALID, IDLE_W); end
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (TX_VALID !== 1'b0 || RX_READY !== 1'b1) begin
      bad++; $display("FAIL reset_discard got txv=%b rxr=%b exp 0 1", TX_VALID, RX_READY); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_attach_ack();
    test_detach_and_timeout();
    test_attach_immediate();
    test_exec(8'h3C, 8'h00, 8'h01, 8'h00, 20'b00000_0111111_01111111, 8'hC3, 8'h3C);
    test_exec(8'h00, 8'h06, 8'h08, 8'h01, 20'b00100_1110111_11111101, 8'h5A, 8'h5A);
    test_exec_detached();
    test_bad_opcode();
    test_status_backpressure();
    test_reset_mid_exec();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expect got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
